// File: rtl/fifo_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_pkg                                                                   |
// | Constants shared by the fifo_sync drain-side adapter and its skid buffer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fifo_pkg;

  localparam int c_SKID_DEPTH      = 2;
  localparam int c_OCC_WIDTH       = 2;
  localparam int c_FIFO_RD_LATENCY = 1;

  typedef logic [c_OCC_WIDTH-1:0] occ_t;

endpackage
`default_nettype wire

// File: rtl/fifo_stream_reader_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_stream_reader_if                                                      |
// | FIFO read port plus valid/ready output stream of the stream reader.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);

  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_dout;
  logic                  fifo_rd_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  // master: the reader itself; slave: the FIFO and downstream consumer side
  modport master (
    input  fifo_empty,
    input  fifo_dout,
    input  m_ready,
    output fifo_rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_dout,
    output m_ready,
    input  fifo_rd_en,
    input  m_valid,
    input  m_data
  );

endinterface
`default_nettype wire

// File: rtl/skid_buf2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | skid_buf2                                                                  |
// | Two-entry register FIFO absorbing the latency of a registered-output source.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module skid_buf2
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output occ_t                  occ
);

  localparam occ_t c_FULL = occ_t'(c_SKID_DEPTH);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;
  occ_t                  r_occ;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head <= '0;
      r_tail <= '0;
      r_occ  <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (r_occ == '0) begin
            r_head <= din;
          end else begin
            r_tail <= din;
          end
          r_occ <= r_occ + occ_t'(1);
        end
        2'b01: begin
          r_head <= r_tail;
          r_occ  <= r_occ - occ_t'(1);
        end
        2'b11: begin
          // Occupancy is unchanged; only the contents shift toward the head.
          if (r_occ == c_FULL) begin
            r_head <= r_tail;
            r_tail <= din;
          end else begin
            r_head <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = r_head;
  assign occ  = r_occ;

endmodule
`default_nettype wire

// File: rtl/fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fifo_stream_reader                                                         |
// | Drives fifo_sync reads and presents the words as a valid/ready stream.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] xfer_count,
  output logic                 busy
);

  // Wide enough for a full skid buffer plus every outstanding read.
  localparam int c_PEND_W = $clog2(c_SKID_DEPTH + c_FIFO_RD_LATENCY + 1);

  logic                  r_inflight;
  logic [CNT_WIDTH-1:0]  r_xfer_count;
  occ_t                  w_occ;
  logic [DATA_WIDTH-1:0] w_head;
  logic                  w_valid;
  logic                  w_pop;
  logic                  w_rd_en;
  logic [c_PEND_W-1:0]   w_pending;

  always_comb begin
    w_valid   = (w_occ != '0);
    w_pop     = w_valid && bus.m_ready;
    // Words the buffer will hold after this edge if no new read is issued.
    w_pending = c_PEND_W'(w_occ) + c_PEND_W'(r_inflight) - c_PEND_W'(w_pop);
    w_rd_en   = en && !bus.fifo_empty && (w_pending < c_PEND_W'(c_SKID_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight   <= 1'b0;
      r_xfer_count <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) begin
        r_xfer_count <= r_xfer_count + CNT_WIDTH'(1);
      end
    end
  end

  skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (r_inflight),
    .pop   (w_pop),
    .din   (bus.fifo_dout),
    .dout  (w_head),
    .occ   (w_occ)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_valid;
  assign bus.m_data     = w_head;
  assign xfer_count     = r_xfer_count;
  assign busy           = r_inflight || w_valid;

endmodule
`default_nettype wire

// File: tb/tb_fifo_stream_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fifo_stream_reader                                                      |
// | Self-checking bench: fifo_sync stand-in, word-level model, vector table.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fifo_stream_reader;

  localparam int DW = 8;
  localparam int CW = 4;

  typedef struct {
    bit          en;
    bit          rdy;
    bit          rd;
    bit          valid;
    logic [7:0]  data;
    int          cnt;
    bit          busy;
  } vec_t;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          en    = 1'b0;
  logic [CW-1:0] xfer_count;
  logic          busy;

  fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

  fifo_stream_reader #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .bus        (bus),
    .xfer_count (xfer_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] exp_q[$];
  int            m_buf;
  bit            m_inflight;
  int            m_count;
  int            delivered;
  bit            s_rd;
  bit            s_empty;
  bit            s_pop;
  int            feed_left;
  int            feed_pct;
  vec_t          vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Mid-cycle: compare the DUT against the word-level model.
  task automatic sample();
    bit exp_rd;
    bit exp_valid;
    @(negedge clk);
    s_empty   = bus.fifo_empty;
    s_rd      = bus.fifo_rd_en;
    exp_valid = (m_buf != 0);
    s_pop     = exp_valid && bus.m_ready;
    exp_rd    = en && !s_empty && ((m_buf + int'(m_inflight) - int'(s_pop)) < 2);
    chk("rd_en_while_empty", 32'(s_rd && s_empty), 32'(0));
    chk("fifo_rd_en", 32'(s_rd), 32'(exp_rd));
    chk("m_valid", 32'(bus.m_valid), 32'(exp_valid));
    if (exp_valid && exp_q.size() > 0) chk("m_data", 32'(bus.m_data), 32'(exp_q[0]));
    chk("busy", 32'(busy), 32'(m_inflight || exp_valid));
    chk("xfer_count", 32'(xfer_count), 32'(m_count % (1 << CW)));
    chk("push_into_full", 32'(m_inflight && m_buf == 2 && !s_pop), 32'(0));
  endtask

  // Just after the edge: update the FIFO stand-in and the model.
  task automatic advance();
    logic [DW-1:0] w;
    @(posedge clk);
    #1;
    if (s_pop) begin
      exp_q.delete(0);
      m_count++;
      delivered++;
    end
    m_buf      = m_buf + int'(m_inflight) - int'(s_pop);
    m_inflight = s_rd && !s_empty;
    if (m_inflight) begin
      w = fq.pop_front();
      bus.fifo_dout = w;
      exp_q.push_back(w);
    end
    if (feed_left > 0 && $urandom_range(0, 99) < feed_pct) begin
      fq.push_back(DW'($urandom));
      feed_left--;
    end
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    fq.delete();
    exp_q.delete();
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    m_buf = 0; m_inflight = 1'b0; m_count = 0; delivered = 0; feed_left = 0;
    #1;
    chk("rst_fifo_rd_en", 32'(bus.fifo_rd_en), 32'(0));
    chk("rst_m_valid", 32'(bus.m_valid), 32'(0));
    chk("rst_m_data", 32'(bus.m_data), 32'(0));
    chk("rst_xfer_count", 32'(xfer_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic load(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) fq.push_back(base + DW'(i));
    bus.fifo_empty = (fq.size() == 0);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((fq.size() != 0 || m_buf != 0 || m_inflight) && n < budget) begin
      sample();
      advance();
      n++;
    end
    chk("drain_in_budget", 32'(n < budget), 32'(1));
  endtask

  initial begin
    int   stall_reads;
    int   n;
    bit   saw_wrap;
    logic [DW-1:0] held;
    logic [CW-1:0] prev;

    bus.m_ready = 1'b0;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout = '0;
    feed_pct = 0;
    #2;

    // Reset then 4 words, cycle by cycle: {en, rdy, rd, valid, data, cnt, busy}
    vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 0, 1'b1};
    vecs[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 1, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 2, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h44, 3, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 4, 1'b0};
    do_reset();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33); fq.push_back(8'h44);
    bus.fifo_empty = 1'b0;
    for (int i = 0; i < 7; i++) begin
      en = vecs[i].en;
      bus.m_ready = vecs[i].rdy;
      sample();
      chk($sformatf("vec%0d_rd_en", i), 32'(bus.fifo_rd_en), 32'(vecs[i].rd));
      chk($sformatf("vec%0d_valid", i), 32'(bus.m_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) chk($sformatf("vec%0d_data", i), 32'(bus.m_data), 32'(vecs[i].data));
      chk($sformatf("vec%0d_count", i), 32'(xfer_count), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].busy));
      advance();
    end

    // Backpressure: 5-cycle stall mid-stream
    do_reset();
    load(8, 8'h80);
    en = 1'b1;
    bus.m_ready = 1'b1;
    repeat (4) begin sample(); advance(); end
    bus.m_ready = 1'b0;
    stall_reads = 0;
    held = '0;
    for (int i = 0; i < 5; i++) begin
      sample();
      if (i == 0) held = bus.m_data;
      else chk("stall_data_hold", 32'(bus.m_data), 32'(held));
      if (bus.fifo_rd_en) stall_reads++;
      advance();
    end
    chk("stall_extra_reads_le1", 32'(stall_reads <= 1), 32'(1));
    bus.m_ready = 1'b1;
    run_until_idle(50);
    chk("bp_xfer_count", 32'(xfer_count), 32'(8));
    chk("bp_delivered", 32'(delivered), 32'(8));

    // Random m_ready and en over 1000 words
    do_reset();
    feed_left = 1000;
    feed_pct = 70;
    n = 0;
    while ((feed_left > 0 || fq.size() != 0 || m_buf != 0 || m_inflight) && n < 8000) begin
      en = ($urandom_range(0, 9) != 0);
      bus.m_ready = $urandom_range(0, 1) != 0;
      sample();
      advance();
      n++;
    end
    chk("rand_in_budget", 32'(n < 8000), 32'(1));
    chk("rand_delivered", 32'(delivered), 32'(1000));
    chk("rand_leftover", 32'(exp_q.size()), 32'(0));

    // en dropped for 3 cycles with the FIFO non-empty
    do_reset();
    load(6, 8'hC0);
    en = 1'b1;
    bus.m_ready = 1'b1;
    repeat (2) begin sample(); advance(); end
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("en_low_no_read", 32'(bus.fifo_rd_en), 32'(0));
      advance();
    end
    en = 1'b1;
    run_until_idle(40);
    chk("en_xfer_count", 32'(xfer_count), 32'(6));
    chk("en_delivered", 32'(delivered), 32'(6));

    // Counter wrap with a 4-bit counter: 17 words
    do_reset();
    load(17, 8'h01);
    saw_wrap = 1'b0;
    prev = '0;
    n = 0;
    while ((fq.size() != 0 || m_buf != 0 || m_inflight) && n < 60) begin
      sample();
      if (prev == 4'hF && xfer_count == 4'h0) saw_wrap = 1'b1;
      prev = xfer_count;
      advance();
      n++;
    end
    chk("wrap_15_to_0_seen", 32'(saw_wrap), 32'(1));
    chk("wrap_final_count", 32'(xfer_count), 32'(1));

    // Asynchronous reset with the buffer full
    do_reset();
    load(6, 8'hA0);
    bus.m_ready = 1'b0;
    n = 0;
    while (m_buf != 2 && n < 10) begin
      sample();
      advance();
      n++;
    end
    chk("reached_full_buffer", 32'(m_buf == 2), 32'(1));
    do_reset();
    load(4, 8'hE1);
    bus.m_ready = 1'b1;
    run_until_idle(30);
    chk("restart_xfer_count", 32'(xfer_count), 32'(4));
    chk("restart_delivered", 32'(delivered), 32'(4));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before t=500000");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
